// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receive path: frame states, prefix bytes, parity helper.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_REL = 8'hF0;
    localparam int         PS2_FRAME_LEN  = 11;

    // Odd parity: data bits plus parity bit must contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous keyboard lines; both flops reset to RST_VAL.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic ck,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge ck) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ps2_frame_rx.sv
// Assembles 11-bit PS/2 frames from per-bit strobes, checks them, and folds E0/F0 prefixes into key events.
// state  | meaning
// IDLE   | waiting for a start bit (d=0 on a strobe)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | next strobe carries the odd-parity bit
// STOP   | next strobe carries the stop bit; frame is judged here
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int TW             = 13
) (
    input  logic       ck,
    input  logic       rst,
    input  logic       bit_stb,
    input  logic       ps2_d,
    output logic [7:0] code,
    output logic       ext,
    output logic       rel,
    output logic       key_vld,
    output logic       frm_err
);

    localparam logic [TW-1:0] TC_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TC_ONE  = TW'(1);

    logic            d_sync;
    ps2_state_t      state, state_nxt;
    logic [2:0]      bit_cnt, bit_cnt_nxt;
    logic [7:0]      shreg, shreg_nxt;
    logic            par_bit, par_bit_nxt;
    logic [TW-1:0]   tcnt, tcnt_nxt;
    logic            ext_pend, ext_pend_nxt;
    logic            rel_pend, rel_pend_nxt;
    logic [7:0]      code_nxt;
    logic            ext_nxt, rel_nxt;
    logic            key_vld_nxt, frm_err_nxt;
    logic            frame_good;

    sync2 #(.RST_VAL(1'b1)) u_sync_d (
        .ck  (ck),
        .rst (rst),
        .d   (ps2_d),
        .q   (d_sync)
    );

    assign frame_good = d_sync && odd_parity_ok(shreg, par_bit);

    always_ff @(posedge ck) begin
        if (rst) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            tcnt     <= '0;
            ext_pend <= 1'b0;
            rel_pend <= 1'b0;
            code     <= '0;
            ext      <= 1'b0;
            rel      <= 1'b0;
            key_vld  <= 1'b0;
            frm_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shreg    <= shreg_nxt;
            par_bit  <= par_bit_nxt;
            tcnt     <= tcnt_nxt;
            ext_pend <= ext_pend_nxt;
            rel_pend <= rel_pend_nxt;
            code     <= code_nxt;
            ext      <= ext_nxt;
            rel      <= rel_nxt;
            key_vld  <= key_vld_nxt;
            frm_err  <= frm_err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        shreg_nxt    = shreg;
        par_bit_nxt  = par_bit;
        tcnt_nxt     = tcnt + TC_ONE;
        ext_pend_nxt = ext_pend;
        rel_pend_nxt = rel_pend;
        code_nxt     = code;
        ext_nxt      = ext;
        rel_nxt      = rel;
        key_vld_nxt  = 1'b0;
        frm_err_nxt  = 1'b0;

        case (state)
            ST_IDLE: begin
                tcnt_nxt = '0;
                // A strobe with d=1 here is treated as a glitch and ignored.
                if (bit_stb && !d_sync) begin
                    state_nxt   = ST_DATA;
                    bit_cnt_nxt = '0;
                end
            end
            ST_DATA: begin
                if (bit_stb) begin
                    shreg_nxt   = {d_sync, shreg[7:1]};
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_nxt = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (bit_stb) begin
                    par_bit_nxt = d_sync;
                    state_nxt   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_stb) begin
                    state_nxt = ST_IDLE;
                    if (!frame_good) begin
                        frm_err_nxt  = 1'b1;
                        ext_pend_nxt = 1'b0;
                        rel_pend_nxt = 1'b0;
                    end else if (shreg == PS2_PREFIX_EXT) begin
                        ext_pend_nxt = 1'b1;
                    end else if (shreg == PS2_PREFIX_REL) begin
                        rel_pend_nxt = 1'b1;
                    end else begin
                        code_nxt     = shreg;
                        ext_nxt      = ext_pend;
                        rel_nxt      = rel_pend;
                        key_vld_nxt  = 1'b1;
                        ext_pend_nxt = 1'b0;
                        rel_pend_nxt = 1'b0;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Inside a frame a strobe restarts the gap timer and takes priority over expiry.
        if (state != ST_IDLE) begin
            if (bit_stb) begin
                tcnt_nxt = '0;
            end else if (tcnt == TC_LAST) begin
                state_nxt    = ST_IDLE;
                bit_cnt_nxt  = '0;
                tcnt_nxt     = '0;
                frm_err_nxt  = 1'b1;
                ext_pend_nxt = 1'b0;
                rel_pend_nxt = 1'b0;
            end
        end
    end

endmodule
